// File: rtl/hdlc_mon_pkg.sv
// Shared types and constants for the HDLC line monitor: FSM states,
// window patterns and readback select codes.
package hdlc_mon_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    OPEN = 1'b1
  } state_e;

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'h7F;

  localparam logic [1:0] RD_FRAME_CNT   = 2'd0;
  localparam logic [1:0] RD_ERR_CNT     = 2'd1;
  localparam logic [1:0] RD_FRAME_BYTES = 2'd2;
  localparam logic [1:0] RD_STATUS      = 2'd3;

endpackage

// File: rtl/hdlc_mon_chan.sv
// Single-channel HDLC line watcher: 8-bit window, flag/abort detection,
// destuffed bit counting, frame delimiting and saturating statistics.
module hdlc_mon_chan
  import hdlc_mon_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_line,
  input  logic             i_bit_en,
  input  logic             i_clr_cnt,
  output logic             o_flag_detect,
  output logic             o_abort_detect,
  output logic             o_frame_done,
  output logic             o_err_align,
  output logic             o_err_abort,
  output logic             o_err_overflow,
  output logic             o_idle,
  output logic             o_in_frame,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_frame_bytes
);

  localparam int              BC_W      = $clog2(8*MAX_BYTES+8) + 1;
  localparam logic [BC_W-1:0] BC_LIMIT  = BC_W'(8*MAX_BYTES+8);
  localparam logic [BC_W-1:0] FLAG_BITS = BC_W'(7);

  logic [7:0]       r_window;
  logic [3:0]       r_ones;
  logic [BC_W-1:0]  r_bitcnt;
  state_e           r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_frame_bytes;
  logic r_flag, r_abort, r_done, r_err_align, r_err_abort, r_err_ovf;
  logic r_idle, r_in_frame;

  logic [7:0]      w_window_next;
  logic [3:0]      w_ones_next;
  logic [BC_W-1:0] w_bitcnt_next;
  logic [BC_W-1:0] w_bitcnt_inc;
  logic [BC_W-1:0] w_data_bits;
  state_e          w_state_next;
  logic w_stuffed, w_flag, w_abort, w_done, w_err_align, w_err_abort, w_err_ovf;
  logic w_frame_inc, w_err_inc;

  always_comb begin
    w_window_next = r_window;
    w_ones_next   = r_ones;
    w_bitcnt_next = r_bitcnt;
    w_state_next  = r_state;
    w_stuffed     = 1'b0;
    w_flag        = 1'b0;
    w_abort       = 1'b0;
    w_done        = 1'b0;
    w_err_align   = 1'b0;
    w_err_abort   = 1'b0;
    w_err_ovf     = 1'b0;
    w_frame_inc   = 1'b0;
    w_err_inc     = 1'b0;
    w_bitcnt_inc  = r_bitcnt + BC_W'(1);
    // Bits counted since the opening flag include the closing flag's first seven
    w_data_bits   = r_bitcnt - FLAG_BITS;

    if (i_bit_en) begin
      w_window_next = {r_window[6:0], i_line};
      if (i_line) begin
        w_ones_next = (r_ones == 4'd15) ? r_ones : r_ones + 4'd1;
      end else begin
        w_ones_next = 4'd0;
      end
      w_stuffed = !i_line && (r_ones == 4'd5);

      if (w_window_next == FLAG_PAT) begin
        w_flag = 1'b1;
        if (r_state == OPEN && r_bitcnt > FLAG_BITS) begin
          if (w_data_bits[2:0] == 3'd0) begin
            w_done      = 1'b1;
            w_frame_inc = 1'b1;
          end else begin
            w_err_align = 1'b1;
            w_err_inc   = 1'b1;
          end
        end
        w_bitcnt_next = '0;
        w_state_next  = OPEN;
      end else if (w_window_next == ABORT_PAT) begin
        w_abort = 1'b1;
        if (r_state == OPEN && r_bitcnt > BC_W'(8)) begin
          w_err_abort = 1'b1;
          w_err_inc   = 1'b1;
        end
        w_state_next = HUNT;
      end else if (r_state == OPEN && !w_stuffed) begin
        w_bitcnt_next = w_bitcnt_inc;
        if (w_bitcnt_inc == BC_LIMIT) begin
          w_err_ovf    = 1'b1;
          w_err_inc    = 1'b1;
          w_state_next = HUNT;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_window      <= '0;
      r_ones        <= '0;
      r_bitcnt      <= '0;
      r_state       <= HUNT;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
      r_frame_bytes <= '0;
      r_flag        <= 1'b0;
      r_abort       <= 1'b0;
      r_done        <= 1'b0;
      r_err_align   <= 1'b0;
      r_err_abort   <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_idle        <= 1'b0;
      r_in_frame    <= 1'b0;
    end else begin
      r_window    <= w_window_next;
      r_ones      <= w_ones_next;
      r_bitcnt    <= w_bitcnt_next;
      r_state     <= w_state_next;
      r_flag      <= w_flag;
      r_abort     <= w_abort;
      r_done      <= w_done;
      r_err_align <= w_err_align;
      r_err_abort <= w_err_abort;
      r_err_ovf   <= w_err_ovf;
      r_idle      <= (w_ones_next >= 4'd8);
      r_in_frame  <= (w_state_next == OPEN);
      if (w_done) begin
        r_frame_bytes <= CNT_W'(w_data_bits >> 3);
      end
      // Clear takes precedence over any increment in the same cycle
      if (i_clr_cnt) begin
        r_frame_cnt <= '0;
        r_err_cnt   <= '0;
      end else begin
        if (w_frame_inc && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if (w_err_inc && r_err_cnt != '1)     r_err_cnt   <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign o_flag_detect  = r_flag;
  assign o_abort_detect = r_abort;
  assign o_frame_done   = r_done;
  assign o_err_align    = r_err_align;
  assign o_err_abort    = r_err_abort;
  assign o_err_overflow = r_err_ovf;
  assign o_idle         = r_idle;
  assign o_in_frame     = r_in_frame;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_err_cnt      = r_err_cnt;
  assign o_frame_bytes  = r_frame_bytes;

endmodule

// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC line monitor: one watcher per tapped line plus a
// registered statistics readback mux.
module hdlc_line_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int MAX_BYTES = 128,
  parameter int CNT_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_line,
  input  logic [CHANNELS-1:0] i_bit_en,
  input  logic                i_clr_cnt,
  input  logic [2:0]          i_rd_ch,
  input  logic [1:0]          i_rd_sel,
  output logic [CNT_W-1:0]    o_rd_data,
  output logic [CHANNELS-1:0] o_flag_detect,
  output logic [CHANNELS-1:0] o_abort_detect,
  output logic [CHANNELS-1:0] o_frame_done,
  output logic [CHANNELS-1:0] o_err_align,
  output logic [CHANNELS-1:0] o_err_abort,
  output logic [CHANNELS-1:0] o_err_overflow,
  output logic [CHANNELS-1:0] o_idle,
  output logic [CHANNELS-1:0] o_in_frame
);

  // Readback arrays span all eight selectable channels; absent ones read as zero
  logic [CNT_W-1:0] w_frame_cnt   [8];
  logic [CNT_W-1:0] w_err_cnt     [8];
  logic [CNT_W-1:0] w_frame_bytes [8];
  logic [7:0]       w_idle;
  logic [7:0]       w_in_frame;
  logic [CNT_W-1:0] w_rd_next;
  logic [CNT_W-1:0] r_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < CHANNELS) begin : g_live
        hdlc_mon_chan #(
          .MAX_BYTES (MAX_BYTES),
          .CNT_W     (CNT_W)
        ) u_chan (
          .i_clk          (i_clk),
          .i_rst_n        (i_rst_n),
          .i_line         (i_line[gi]),
          .i_bit_en       (i_bit_en[gi]),
          .i_clr_cnt      (i_clr_cnt),
          .o_flag_detect  (o_flag_detect[gi]),
          .o_abort_detect (o_abort_detect[gi]),
          .o_frame_done   (o_frame_done[gi]),
          .o_err_align    (o_err_align[gi]),
          .o_err_abort    (o_err_abort[gi]),
          .o_err_overflow (o_err_overflow[gi]),
          .o_idle         (w_idle[gi]),
          .o_in_frame     (w_in_frame[gi]),
          .o_frame_cnt    (w_frame_cnt[gi]),
          .o_err_cnt      (w_err_cnt[gi]),
          .o_frame_bytes  (w_frame_bytes[gi])
        );
      end else begin : g_none
        assign w_frame_cnt[gi]   = '0;
        assign w_err_cnt[gi]     = '0;
        assign w_frame_bytes[gi] = '0;
        assign w_idle[gi]        = 1'b0;
        assign w_in_frame[gi]    = 1'b0;
      end
    end
  endgenerate

  assign o_idle     = w_idle[CHANNELS-1:0];
  assign o_in_frame = w_in_frame[CHANNELS-1:0];

  always_comb begin
    w_rd_next = '0;
    case (i_rd_sel)
      RD_FRAME_CNT:   w_rd_next = w_frame_cnt[i_rd_ch];
      RD_ERR_CNT:     w_rd_next = w_err_cnt[i_rd_ch];
      RD_FRAME_BYTES: w_rd_next = w_frame_bytes[i_rd_ch];
      RD_STATUS:      w_rd_next = {{(CNT_W-2){1'b0}}, w_in_frame[i_rd_ch], w_idle[i_rd_ch]};
      default:        w_rd_next = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Scoreboarded bench for hdlc_line_monitor: a bit-history reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_hdlc_line_monitor;
  localparam int CH    = 2;
  localparam int MAXB  = 128;
  localparam int CW    = 16;
  localparam int LIMIT = 8*MAXB + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [CH-1:0] line = '0, bit_en = '0;
  logic          clr = 1'b0;
  logic [2:0]    rd_ch = '0;
  logic [1:0]    rd_sel = '0;
  logic [CW-1:0] rd_data;
  logic [CH-1:0] flag_d, abort_d, done, e_align, e_abort, e_ovf, idle, in_frame;

  hdlc_line_monitor #(.CHANNELS(CH), .MAX_BYTES(MAXB), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_line(line), .i_bit_en(bit_en),
    .i_clr_cnt(clr), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel), .o_rd_data(rd_data),
    .o_flag_detect(flag_d), .o_abort_detect(abort_d), .o_frame_done(done),
    .o_err_align(e_align), .o_err_abort(e_abort), .o_err_overflow(e_ovf),
    .o_idle(idle), .o_in_frame(in_frame)
  );

  typedef struct packed {
    logic [CH-1:0] flag, abort, done, align, eabort, ovf, idle, inf;
    logic [CW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  int seen_flag[CH], seen_abort[CH], seen_done[CH], seen_align[CH], seen_eabort[CH], seen_ovf[CH];

  // Reference model: recent line history plus frame-level bookkeeping
  bit [15:0] m_hist[CH];
  int        m_bitcnt[CH], m_fcnt[CH], m_ecnt[CH], m_fbytes[CH];
  bit        m_open[CH], m_idle[CH];

  bit q0[$], q1[$];
  int tx_ones[CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int trail_ones(input bit [15:0] h);
    int n = 0;
    while (n < 15 && h[n]) n++;
    return n;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  // One clock of stimulus; the model predicts the outputs after the next edge
  task automatic cyc(input logic r, input logic [CH-1:0] ln, input logic [CH-1:0] en,
                     input logic c, input logic [2:0] rc, input logic [1:0] rs);
    exp_t e;
    bit st;
    bit [7:0] w;
    int n;
    @(negedge clk);
    rst_n = r; line = ln; bit_en = en; clr = c; rd_ch = rc; rd_sel = rs;
    e = '0;
    if (r && rc < CH) begin
      case (rs)
        2'd0: e.rd = CW'(m_fcnt[rc]);
        2'd1: e.rd = CW'(m_ecnt[rc]);
        2'd2: e.rd = CW'(m_fbytes[rc]);
        default: e.rd = CW'({m_open[rc], m_idle[rc]});
      endcase
    end
    for (int k = 0; k < CH; k++) begin
      if (!r) begin
        m_hist[k] = '0; m_bitcnt[k] = 0; m_open[k] = 0; m_idle[k] = 0;
        m_fcnt[k] = 0; m_ecnt[k] = 0; m_fbytes[k] = 0;
      end else begin
        if (en[k]) begin
          st = !ln[k] && trail_ones(m_hist[k]) == 5;
          m_hist[k] = {m_hist[k][14:0], ln[k]};
          w = m_hist[k][7:0];
          if (w == 8'h7E) begin
            e.flag[k] = 1'b1;
            if (m_open[k] && m_bitcnt[k] > 7) begin
              n = m_bitcnt[k] - 7;
              if (n % 8 == 0) begin
                e.done[k] = 1'b1; m_fbytes[k] = n / 8; m_fcnt[k] = sat_inc(m_fcnt[k]);
              end else begin
                e.align[k] = 1'b1; m_ecnt[k] = sat_inc(m_ecnt[k]);
              end
            end
            m_bitcnt[k] = 0; m_open[k] = 1;
          end else if (w == 8'h7F) begin
            e.abort[k] = 1'b1;
            if (m_open[k] && m_bitcnt[k] > 8) begin
              e.eabort[k] = 1'b1; m_ecnt[k] = sat_inc(m_ecnt[k]);
            end
            m_open[k] = 0;
          end else if (m_open[k] && !st) begin
            m_bitcnt[k]++;
            if (m_bitcnt[k] == LIMIT) begin
              e.ovf[k] = 1'b1; m_ecnt[k] = sat_inc(m_ecnt[k]); m_open[k] = 0;
            end
          end
          m_idle[k] = trail_ones(m_hist[k]) >= 8;
        end
        if (c) begin m_fcnt[k] = 0; m_ecnt[k] = 0; end
      end
      e.idle[k] = m_idle[k];
      e.inf[k]  = m_open[k];
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("flag_detect", 32'(flag_d), 32'(mon_e.flag));
      chk("abort_detect", 32'(abort_d), 32'(mon_e.abort));
      chk("frame_done", 32'(done), 32'(mon_e.done));
      chk("err_align", 32'(e_align), 32'(mon_e.align));
      chk("err_abort", 32'(e_abort), 32'(mon_e.eabort));
      chk("err_overflow", 32'(e_ovf), 32'(mon_e.ovf));
      chk("idle", 32'(idle), 32'(mon_e.idle));
      chk("in_frame", 32'(in_frame), 32'(mon_e.inf));
      chk("rd_data", 32'(rd_data), 32'(mon_e.rd));
      for (int k = 0; k < CH; k++) begin
        seen_flag[k]   += int'(flag_d[k]);
        seen_abort[k]  += int'(abort_d[k]);
        seen_done[k]   += int'(done[k]);
        seen_align[k]  += int'(e_align[k]);
        seen_eabort[k] += int'(e_abort[k]);
        seen_ovf[k]    += int'(e_ovf[k]);
      end
    end
  end

  task automatic zero_seen();
    for (int k = 0; k < CH; k++) begin
      seen_flag[k] = 0; seen_abort[k] = 0; seen_done[k] = 0;
      seen_align[k] = 0; seen_eabort[k] = 0; seen_ovf[k] = 0;
    end
  endtask

  task automatic push_bit(input int ch, input bit b);
    if (ch == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic add_data_bit(input int ch, input bit b);
    push_bit(ch, b);
    if (b) begin
      tx_ones[ch]++;
      if (tx_ones[ch] == 5) begin push_bit(ch, 1'b0); tx_ones[ch] = 0; end
    end else begin
      tx_ones[ch] = 0;
    end
  endtask

  task automatic add_byte(input int ch, input bit [7:0] v);
    for (int i = 0; i < 8; i++) add_data_bit(ch, v[i]);
  endtask

  task automatic add_flag(input int ch);
    bit [7:0] f = 8'h7E;
    for (int i = 0; i < 8; i++) push_bit(ch, f[i]);
    tx_ones[ch] = 0;
  endtask

  task automatic add_abort(input int ch);
    push_bit(ch, 1'b0);
    repeat (7) push_bit(ch, 1'b1);
    tx_ones[ch] = 0;
  endtask

  task automatic run(input int gap_pct, input int clr_pct, input bit clr_on_last, input int max_cyc);
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < max_cyc) begin
      logic [CH-1:0] ln, en;
      logic c;
      ln = CH'($urandom);
      en = '0;
      c = ($urandom_range(99) < clr_pct);
      if (q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
        en[0] = 1'b1; ln[0] = q0.pop_front();
        if (clr_on_last && q0.size() == 0) c = 1'b1;
      end
      if (q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
        en[1] = 1'b1; ln[1] = q1.pop_front();
      end
      cyc(1'b1, ln, en, c, 3'($urandom), 2'($urandom));
      guard++;
    end
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic readback(input string nm, input int ch, input int sel, input int expv);
    cyc(1'b1, '0, '0, 1'b0, 3'(ch), 2'(sel));
    settle();
    chk(nm, 32'(rd_data), 32'(expv));
  endtask

  task automatic rand_frame(input int ch);
    int kind = $urandom_range(0, 5);
    int n;
    add_flag(ch);
    case (kind)
      0, 1, 2: begin
        n = $urandom_range(0, 6);
        repeat (n) add_byte(ch, 8'($urandom));
        add_flag(ch);
      end
      3: begin
        n = $urandom_range(1, 30);
        repeat (n) add_data_bit(ch, 1'($urandom));
        add_flag(ch);
      end
      4: begin
        n = $urandom_range(0, 4);
        repeat (n) add_byte(ch, 8'($urandom));
        add_abort(ch);
      end
      default: begin
        n = $urandom_range(4, 20);
        repeat (n) push_bit(ch, 1'($urandom));
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    for (int k = 0; k < CH; k++) tx_ones[k] = 0;
    repeat (3) cyc(1'b0, '0, '0, 1'b0, 3'd0, 2'd0);
    settle();
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_in_frame", 32'(in_frame), 32'd0);

    // Eight ones on ch0 -> idle
    zero_seen();
    repeat (8) push_bit(0, 1'b1);
    run(0, 0, 0, 100);
    settle();
    chk("t1_idle", 32'(idle[0]), 32'd1);
    chk("t1_no_flag", 32'(seen_flag[0]), 32'd0);
    readback("t1_status", 0, 3, 1);

    // Good two-byte frame with one stuffed zero
    zero_seen();
    add_flag(0); add_byte(0, 8'hFF); add_byte(0, 8'h01); add_flag(0);
    run(0, 0, 0, 200);
    settle();
    chk("t2_done", 32'(seen_done[0]), 32'd1);
    readback("t2_frame_bytes", 0, 2, 2);
    readback("t2_frame_cnt", 0, 0, 1);

    // 13 data bits -> alignment error
    zero_seen();
    add_flag(0);
    repeat (13) add_data_bit(0, 1'($urandom));
    add_flag(0);
    run(0, 0, 0, 200);
    settle();
    chk("t3_align", 32'(seen_align[0]), 32'd1);
    chk("t3_no_done", 32'(seen_done[0]), 32'd0);
    readback("t3_err_cnt", 0, 1, 1);
    readback("t3_frame_cnt", 0, 0, 1);

    // Abort on ch1 while ch0 closes a short frame
    zero_seen();
    add_flag(1); repeat (3) add_byte(1, 8'hA5); add_abort(1); add_byte(1, 8'hA5);
    add_flag(0); add_byte(0, 8'h3C); add_flag(0);
    run(10, 0, 0, 500);
    settle();
    chk("t4_abort", 32'(seen_abort[1]), 32'd1);
    chk("t4_err_abort", 32'(seen_eabort[1]), 32'd1);
    chk("t4_no_done_ch1", 32'(seen_done[1]), 32'd0);
    chk("t4_in_frame_ch1", 32'(in_frame[1]), 32'd0);
    chk("t4_ch0_done", 32'(seen_done[0]), 32'd1);
    chk("t4_ch0_no_abort", 32'(seen_eabort[0] + seen_abort[0]), 32'd0);

    // 129 bytes -> overflow, closing flag reopens without FrameDone
    zero_seen();
    add_flag(0); repeat (129) add_byte(0, 8'h55); add_flag(0);
    run(20, 0, 0, 5000);
    settle();
    chk("t5_overflow", 32'(seen_ovf[0]), 32'd1);
    chk("t5_no_done", 32'(seen_done[0]), 32'd0);
    chk("t5_in_frame", 32'(in_frame[0]), 32'd1);
    readback("t5_err_cnt", 0, 1, 2);

    // Back-to-back flags, then ClrCnt coincident with FrameDone, with gaps
    zero_seen();
    add_flag(0); add_flag(0); add_flag(0);
    run(0, 0, 0, 100);
    settle();
    chk("t6_flags", 32'(seen_flag[0]), 32'd3);
    chk("t6_no_done", 32'(seen_done[0]), 32'd0);
    zero_seen();
    add_flag(0); repeat (3) add_byte(0, 8'($urandom)); add_flag(0);
    run(40, 0, 1, 500);
    settle();
    chk("t6_done", 32'(seen_done[0]), 32'd1);
    readback("t6_frame_cnt_cleared", 0, 0, 0);
    readback("t6_frame_bytes", 0, 2, 3);

    // Reset in the middle of frames on both channels
    zero_seen();
    add_flag(0); repeat (6) add_byte(0, 8'h33); add_flag(0);
    add_flag(1); repeat (6) add_byte(1, 8'h33); add_flag(1);
    run(0, 0, 0, 30);
    cyc(1'b0, '0, '0, 1'b0, 3'd0, 2'd0);
    run(0, 0, 0, 500);
    settle();
    chk("t7_no_done", 32'(seen_done[0] + seen_done[1]), 32'd0);
    readback("t7_frame_bytes", 0, 2, 0);

    // Randomized traffic on both channels
    for (int it = 0; it < 120; it++) begin
      rand_frame(0);
      rand_frame(1);
      run(25, 2, 0, 5000);
    end
    repeat (3) cyc(1'b1, '0, '0, 1'b0, 3'($urandom), 2'($urandom));
    settle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
